// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// command opcodes, controller state encoding and default widths.
package pipeline_ctrl_pkg;

  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_CNT_W  = 32;

  localparam logic [1:0] CMD_HALT  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    PC_HALTED   = 2'b00,
    PC_RUNNING  = 2'b01,
    PC_STEPPING = 2'b10
  } pc_state_t;

endpackage

// File: rtl/sat_counter.sv
// Counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/step/halt sequencer for the pipeline registers: load enables, bubbles,
// PC write, per-stage valid tracking and debug counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_count,
  output logic              cmd_err,
  input  logic              stall_req,
  input  logic              branch_taken,
  input  logic              jump_taken,
  input  logic              halt_instr,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] flush,
  output logic              pc_write,
  output logic [STAGES-1:0] stage_valid,
  output logic              busy,
  output logic              done,
  output logic              halted_by_instr,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  pc_state_t         state;
  logic [STEP_W-1:0] remaining;
  logic              adv;
  logic              halt_cmd;
  logic              instr_halt;
  logic              last_step;
  logic              stop;
  logic              cmd_reject;
  logic              clear_acc;

  always_comb begin
    adv         = (state != PC_HALTED);
    pc_write    = adv & ~stall_req;
    stage_en    = {STAGES{adv}};
    stage_en[0] = pc_write;
    // A stall suppresses the redirect; ID re-presents it once the stall clears.
    flush       = '0;
    flush[0]    = pc_write & (branch_taken | jump_taken);
    flush[1]    = adv & stall_req;
    busy        = adv;

    halt_cmd    = cmd_valid && (cmd_op == CMD_HALT);
    instr_halt  = adv && halt_instr && stage_valid[STAGES-1];
    last_step   = (state == PC_STEPPING) && (remaining == STEP_W'(1));
    stop        = adv && (halt_cmd || instr_halt || last_step);
    cmd_reject  = cmd_valid && (cmd_op != CMD_HALT) && adv;
    clear_acc   = cmd_valid && (cmd_op == CMD_CLEAR) && !adv;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= PC_HALTED;
      remaining       <= '0;
      stage_valid     <= '0;
      done            <= 1'b0;
      cmd_err         <= 1'b0;
      halted_by_instr <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= cmd_reject;

      if (adv) begin
        if (stage_en[0]) begin
          stage_valid[0] <= ~flush[0];
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
          stage_valid[i] <= stage_valid[i-1] & ~flush[i];
        end
      end

      case (state)
        PC_HALTED: begin
          if (cmd_valid) begin
            case (cmd_op)
              CMD_RUN: begin
                state           <= PC_RUNNING;
                halted_by_instr <= 1'b0;
              end
              CMD_STEP: begin
                halted_by_instr <= 1'b0;
                if (cmd_count == '0) begin
                  done <= 1'b1;
                end else begin
                  remaining <= cmd_count;
                  state     <= PC_STEPPING;
                end
              end
              CMD_CLEAR: stage_valid <= '0;
              default: ;
            endcase
          end
        end
        default: begin
          if (stop) begin
            state     <= PC_HALTED;
            remaining <= '0;
            done      <= 1'b1;
            if (instr_halt) begin
              halted_by_instr <= 1'b1;
            end
          end else if (state == PC_STEPPING) begin
            remaining <= remaining - 1'b1;
          end
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (adv),
    .clr   (clear_acc),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (adv & stage_valid[STAGES-1]),
    .clr   (clear_acc),
    .count (retire_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int STAGES = 4;
  localparam int STEP_W = 16;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [STEP_W-1:0] cmd_count = '0;
  logic              cmd_err;
  logic              stall_req = 1'b0;
  logic              branch_taken = 1'b0;
  logic              jump_taken = 1'b0;
  logic              halt_instr = 1'b0;
  logic [STAGES-1:0] stage_en, flush, stage_valid;
  logic              pc_write, busy, done, halted_by_instr;
  logic [CNT_W-1:0]  cycle_count, retire_count;

  always #5 clock = ~clock;

  pipeline_ctrl #(.STAGES(STAGES), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_op          (cmd_op),
    .cmd_count       (cmd_count),
    .cmd_err         (cmd_err),
    .stall_req       (stall_req),
    .branch_taken    (branch_taken),
    .jump_taken      (jump_taken),
    .halt_instr      (halt_instr),
    .stage_en        (stage_en),
    .flush           (flush),
    .pc_write        (pc_write),
    .stage_valid     (stage_valid),
    .busy            (busy),
    .done            (done),
    .halted_by_instr (halted_by_instr),
    .cycle_count     (cycle_count),
    .retire_count    (retire_count)
  );

  int errors = 0;
  int checks = 0;

  // Model: free-running flag plus outstanding step budget; halted when neither.
  bit              m_run;
  int              m_rem;
  bit [STAGES-1:0] m_valid;
  int              m_cyc, m_ret;
  bit              m_done, m_err, m_hbi;

  logic [STAGES-1:0] s_en, s_fl, s_valid;
  logic              s_pc, s_busy, s_done, s_err, s_hbi;
  logic [CNT_W-1:0]  s_cyc, s_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_rem = 0; m_valid = '0; m_cyc = 0; m_ret = 0;
    m_done = 0; m_err = 0; m_hbi = 0;
  endtask

  task automatic do_cycle(input bit cv, input logic [1:0] op, input int cnt,
                          input bit st, input bit br, input bit jp, input bit hi);
    bit              adv, last, stop;
    bit [STAGES-1:0] e_en, e_fl, nv;
    cmd_valid = cv; cmd_op = op; cmd_count = STEP_W'(cnt);
    stall_req = st; branch_taken = br; jump_taken = jp; halt_instr = hi;
    @(negedge clock);
    s_en = stage_en; s_fl = flush; s_valid = stage_valid; s_pc = pc_write;
    s_busy = busy; s_done = done; s_err = cmd_err; s_hbi = halted_by_instr;
    s_cyc = cycle_count; s_ret = retire_count;

    adv  = m_run || (m_rem > 0);
    last = m_valid[STAGES-1];
    for (int i = 0; i < STAGES; i++) e_en[i] = adv;
    e_en[0] = adv && !st;
    e_fl = '0;
    e_fl[0] = adv && !st && (br || jp);
    e_fl[1] = adv && st;
    chk("model_stage_en", s_en, e_en);
    chk("model_flush", s_fl, e_fl);
    chk("model_pc_write", s_pc, adv && !st);
    chk("model_busy", s_busy, adv);
    chk("model_stage_valid", s_valid, m_valid);
    chk("model_done", s_done, m_done);
    chk("model_cmd_err", s_err, m_err);
    chk("model_halted_by_instr", s_hbi, m_hbi);
    chk("model_cycle_count", s_cyc, m_cyc);
    chk("model_retire_count", s_ret, m_ret);

    nv = m_valid;
    if (adv) begin
      nv[0] = st ? m_valid[0] : !(br || jp);
      for (int i = 1; i < STAGES; i++) nv[i] = m_valid[i-1] && !(i == 1 && st);
      if (m_cyc < CMAX) m_cyc++;
      if (last && m_ret < CMAX) m_ret++;
    end
    m_done = 0;
    m_err  = cv && (op != CMD_HALT) && adv;
    if (adv) begin
      stop = (cv && op == CMD_HALT) || (hi && last) || (!m_run && m_rem == 1);
      if (stop) begin
        m_run = 0; m_rem = 0; m_done = 1;
        if (hi && last) m_hbi = 1;
      end else if (!m_run) begin
        m_rem--;
      end
    end else if (cv) begin
      case (op)
        CMD_RUN:   begin m_run = 1; m_hbi = 0; end
        CMD_STEP:  begin m_hbi = 0; if (cnt == 0) m_done = 1; else m_rem = cnt; end
        CMD_CLEAR: begin m_cyc = 0; m_ret = 0; nv = '0; end
        default: ;
      endcase
    end
    m_valid = nv;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(0, CMD_HALT, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stage_en"}, stage_en, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_pc_write"}, pc_write, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stage_valid"}, stage_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cmd_err"}, cmd_err, 0);
    chk({tag, "_hbi"}, halted_by_instr, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
    chk({tag, "_retire_count"}, retire_count, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // STEP 3 from a clean pipeline
    do_cycle(1, CMD_STEP, 3, 0, 0, 0, 0);
    chk("step_cmd_cycle_en", s_en, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("step_en", s_en, 4'b1111);
      chk("step_busy", s_busy, 1);
    end
    idle(1);
    chk("step_done", s_done, 1);
    chk("step_halted", s_busy, 0);
    chk("step_cycle_count", s_cyc, 3);
    chk("step_valid", s_valid, 4'b0111);
    chk("step_retire", s_ret, 0);
    idle(1);
    chk("step_done_once", s_done, 0);

    // Stall, then stall+branch, then branch alone
    do_cycle(1, CMD_RUN, 0, 0, 0, 0, 0);
    do_cycle(0, CMD_HALT, 0, 1, 0, 0, 0);
    chk("stall_pc_write", s_pc, 0);
    chk("stall_en", s_en, 4'b1110);
    chk("stall_flush", s_fl, 4'b0010);
    do_cycle(0, CMD_HALT, 0, 1, 1, 0, 0);
    chk("stall_bubble_valid1", s_valid[1], 0);
    chk("stall_branch_flush", s_fl, 4'b0010);
    do_cycle(0, CMD_HALT, 0, 0, 1, 0, 0);
    chk("branch_flush", s_fl, 4'b0001);
    do_cycle(1, CMD_HALT, 0, 0, 0, 0, 0);
    idle(1);
    chk("halt_cmd_done", s_done, 1);

    // HALT instruction reaching the last stage
    do_cycle(1, CMD_CLEAR, 0, 0, 0, 0, 0);
    do_cycle(1, CMD_RUN, 0, 0, 0, 0, 0);
    idle(6);
    do_cycle(0, CMD_HALT, 0, 0, 0, 0, 1);
    chk("hi_valid3", s_valid[3], 1);
    idle(1);
    chk("hi_done", s_done, 1);
    chk("hi_hbi", s_hbi, 1);
    chk("hi_retire", s_ret, 3);
    chk("hi_cycles", s_cyc, 7);
    chk("hi_halted", s_busy, 0);

    // Rejected commands
    do_cycle(1, CMD_RUN, 0, 0, 0, 0, 0);
    do_cycle(1, CMD_RUN, 0, 0, 0, 0, 0);
    idle(1);
    chk("run_in_run_err", s_err, 1);
    chk("run_in_run_busy", s_busy, 1);
    do_cycle(1, CMD_CLEAR, 0, 0, 0, 0, 0);
    idle(1);
    chk("clear_in_run_err", s_err, 1);
    chk("clear_in_run_busy", s_busy, 1);
    do_cycle(1, CMD_HALT, 0, 0, 0, 0, 0);
    do_cycle(1, CMD_STEP, 20, 0, 0, 0, 0);
    do_cycle(1, CMD_STEP, 5, 0, 0, 0, 0);
    idle(1);
    chk("step_in_step_err", s_err, 1);
    chk("step_in_step_busy", s_busy, 1);
    do_cycle(1, CMD_HALT, 0, 0, 0, 0, 0);
    idle(1);

    // STEP 0, CLEAR, saturation
    do_cycle(1, CMD_STEP, 0, 0, 0, 0, 0);
    idle(1);
    chk("step0_done", s_done, 1);
    chk("step0_halted", s_busy, 0);
    do_cycle(1, CMD_CLEAR, 0, 0, 0, 0, 0);
    idle(1);
    chk("clear_cycles", s_cyc, 0);
    chk("clear_retire", s_ret, 0);
    chk("clear_valid", s_valid, 0);
    do_cycle(1, CMD_RUN, 0, 0, 0, 0, 0);
    idle(70);
    do_cycle(1, CMD_HALT, 0, 0, 0, 0, 0);
    idle(1);
    chk("sat_cycles", s_cyc, CMAX);
    chk("sat_retire", s_ret, CMAX);

    // Asynchronous reset in the middle of a long step
    do_cycle(1, CMD_STEP, 100, 0, 0, 0, 0);
    idle(40);
    chk("midstep_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midstep_reset");
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      do_cycle($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 12)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
